// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: load/store unit bridging EXU memory ops to a valid/ready bus with alignment, funct3 and timeout faults
module ysyx_23060332_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state;
  logic        op_wen;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, sh, ld;
  logic [4:0]  rd;
  logic [7:0]  cnt;
  logic        fire, store, bad_f3, misal;
  assign in_ready      = rst && state == IDLE;
  assign fire          = in_valid && in_ready;
  assign store         = in_wen && !in_ren;
  assign bad_f3        = store ? (in_funct3[2] || in_funct3[1:0] == 2'b11)
                               : (in_funct3[1:0] == 2'b11 || in_funct3 == 3'b110);
  assign misal         = (in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                         (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
  assign mem_req_valid = state == REQ;
  assign mem_req_addr  = {addr[31:2], 2'b00};
  assign mem_req_wen   = op_wen;
  assign mem_req_wstrb = !op_wen ? 4'b0000 :
                         f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                         f3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign mem_req_wdata = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                         f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign sh            = mem_rsp_rdata >> {addr[1:0], 3'b000};
  assign ld            = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                         f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                         f3 == 3'b100 ? {24'b0, sh[7:0]} :
                         f3 == 3'b101 ? {16'b0, sh[15:0]} : mem_rsp_rdata;
  // FSM: capture and fault-screen in IDLE, hold the request in REQ, await response or timeout in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_wen    <= 1'b0;
      f3        <= 3'b000;
      addr      <= 32'b0;
      wdata     <= 32'b0;
      rd        <= 5'b0;
      cnt       <= 8'b0;
      reg_waddr <= 5'b0;
      reg_wdata <= 32'b0;
      reg_wen   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= 2'b00;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= 2'b00;
      reg_wen   <= 1'b0;
      case (state)
        IDLE: if (fire) begin
          op_wen <= store;
          f3     <= in_funct3;
          addr   <= in_addr;
          wdata  <= in_wdata;
          rd     <= in_rd;
          if (bad_f3 || misal) begin
            err       <= 1'b1;
            err_cause <= bad_f3 ? 2'b10 : 2'b01;
          end else state <= REQ;
        end
        REQ: if (mem_req_ready) begin
          state <= WAIT;
          cnt   <= 8'b0;
        end
        WAIT: if (mem_rsp_valid) begin
          state <= IDLE;
          done  <= 1'b1;
          if (!op_wen && rd != 5'b0) begin
            reg_wen   <= 1'b1;
            reg_waddr <= rd;
            reg_wdata <= ld;
          end
        end else if (cnt == 8'(TIMEOUT_CYCLES)) begin
          state     <= IDLE;
          err       <= 1'b1;
          err_cause <= 2'b11;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// tb_ysyx_23060332_lsu: randomized scoreboard bench with a bus responder and a retirement monitor
module tb_ysyx_23060332_lsu;
  localparam int T = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen, done, err;
  logic [1:0]  err_cause;

  ysyx_23060332_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren),
    .in_wen(in_wen), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .done(done),
    .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [1:0]  cause;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stall;
    int          delay;
    logic [31:0] rdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input int stall, input int delay, input logic [31:0] rdata,
                       input bit track);
    exp_t        e;
    req_t        r;
    int          size, k;
    bit          legal;
    logic [31:0] w, v;
    e     = '{default: 0};
    legal = st ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f[1:0];
    if (!legal) begin
      e.is_err = 1'b1;
      e.cause  = 2'b10;
    end else if (a % size != 0) begin
      e.is_err = 1'b1;
      e.cause  = 2'b01;
    end else begin
      r.addr  = a & ~32'd3;
      r.wen   = st;
      r.wdata = size == 1 ? wd[7:0] * 32'h01010101 : size == 2 ? wd[15:0] * 32'h00010001 : wd;
      r.wstrb = st ? 4'(((1 << size) - 1) << (a % 4)) : 4'b0000;
      r.stall = stall;
      r.delay = delay;
      r.rdata = rdata;
      req_q.push_back(r);
      if (delay > T) begin
        e.is_err = 1'b1;
        e.cause  = 2'b11;
      end else if (!st && rd != 0) begin
        w = rdata >> (8 * (a % 4));
        v = size == 4 ? w : w & ((32'd1 << (8 * size)) - 1);
        if (size < 4 && !f[2] && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
        e.wen   = 1'b1;
        e.waddr = rd;
        e.wdata = v;
      end
    end
    if (track) exp_q.push_back(e);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("in_ready_wait", {31'b0, in_ready}, 1);
    in_valid  = 1'b1;
    in_wen    = st;
    in_ren    = !st;
    in_funct3 = f;
    in_addr   = a;
    in_wdata  = wd;
    in_rd     = rd;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;
    if (track) begin
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) begin
        check("drain", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  endtask

  // Bus responder: verifies each request, stalls it, then answers after the chosen delay
  initial begin
    req_t        r;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'b0;
    forever begin
      @(negedge clk);
      if (rst && mem_req_valid) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", {31'b0, mem_req_valid}, 0);
          r = '{default: 0};
        end else begin
          r = req_q.pop_front();
          check("req_addr", mem_req_addr, r.addr);
          check("req_wen", {31'b0, mem_req_wen}, {31'b0, r.wen});
          check("req_wdata", r.wen ? mem_req_wdata : 32'b0, r.wen ? r.wdata : 32'b0);
          check("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, r.wstrb});
        end
        s_addr  = mem_req_addr;
        s_wdata = mem_req_wdata;
        s_wstrb = mem_req_wstrb;
        for (int i = 0; i < r.stall; i++) begin
          @(negedge clk);
          if (!rst) break;
          check("stall_valid", {31'b0, mem_req_valid}, 1);
          check("stall_addr", mem_req_addr, s_addr);
          check("stall_wdata", mem_req_wdata, s_wdata);
          check("stall_wstrb", {28'b0, mem_req_wstrb}, {28'b0, s_wstrb});
          check("stall_in_ready", {31'b0, in_ready}, 0);
        end
        if (!rst) continue;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (r.delay) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = r.rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every done/err pulse and checks write-back hold behaviour
  initial begin
    exp_t        e;
    logic [4:0]  last_a;
    logic [31:0] last_d;
    last_a = 5'b0;
    last_d = 32'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_a = 5'b0;
        last_d = 32'b0;
      end else begin
        if (done && err) check("done_err_excl", {30'b0, done, err}, 32'b10);
        if (done || err) begin
          if (exp_q.size() == 0) check("unexpected_out", {30'b0, done, err}, 0);
          else begin
            e = exp_q.pop_front();
            check("err", {31'b0, err}, {31'b0, e.is_err});
            check("done", {31'b0, done}, {31'b0, !e.is_err});
            if (e.is_err) check("err_cause", {30'b0, err_cause}, {30'b0, e.cause});
            check("reg_wen", {31'b0, reg_wen}, {31'b0, e.wen});
            if (e.wen) begin
              check("reg_waddr", {27'b0, reg_waddr}, {27'b0, e.waddr});
              check("reg_wdata", reg_wdata, e.wdata);
            end else begin
              check("hold_waddr", {27'b0, reg_waddr}, {27'b0, last_a});
              check("hold_wdata", reg_wdata, last_d);
            end
          end
        end else if (reg_wen) check("stray_reg_wen", {31'b0, reg_wen}, 0);
        if (reg_wen) begin
          last_a = reg_waddr;
          last_d = reg_wdata;
        end
      end
    end
  end

  initial begin
    logic        st;
    logic [2:0]  f;
    logic [31:0] a;
    logic [2:0]  ld_ops [5];
    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_funct3 = 3'b0;
    in_addr = 32'b0; in_wdata = 32'b0; in_rd = 5'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_req_valid", {31'b0, mem_req_valid}, 0);
    check("rst_outs", {28'b0, done, err, reg_wen, mem_req_wen}, 0);
    check("rst_err_cause", {30'b0, err_cause}, 0);
    check("rst_wstrb", {28'b0, mem_req_wstrb}, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("rel_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    issue(0, 3'b000, 32'h80000003, 32'h0, 5'd5, 0, 1, 32'h80FF1234, 1);
    issue(1, 3'b001, 32'h80000002, 32'h0000BEEF, 5'd0, 0, 0, 32'h0, 1);
    issue(0, 3'b010, 32'h80000001, 32'h0, 5'd3, 0, 0, 32'h0, 1);
    issue(1, 3'b010, 32'h80000010, 32'hCAFEF00D, 5'd0, 4, 1, 32'h0, 1);
    issue(0, 3'b010, 32'h80000020, 32'h0, 5'd7, 0, T + 1, 32'h11111111, 1);
    issue(0, 3'b010, 32'h80000024, 32'h0, 5'd8, 0, T, 32'h22223333, 1);
    issue(0, 3'b100, 32'h80000031, 32'h0, 5'd0, 1, 2, 32'hFFFFFFFF, 1);
    issue(0, 3'b101, 32'h80000032, 32'h0, 5'd9, 0, 0, 32'h9ABC0000, 1);
    issue(0, 3'b011, 32'h80000001, 32'h0, 5'd4, 0, 0, 32'h0, 1);
    issue(1, 3'b100, 32'h80000000, 32'h0, 5'd0, 0, 0, 32'h0, 1);
    issue(1, 3'b000, 32'h80000041, 32'h000000A5, 5'd0, 2, 0, 32'h0, 1);
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
      a = 32'h80000000 | ($urandom & 32'h0000FFFC);
      if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(0, 3));
      else if (f[1:0] == 2'b00) a = a | 32'($urandom_range(0, 3));
      else if (f[1:0] == 2'b01) a = a | 32'(2 * $urandom_range(0, 1));
      issue(st, f, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 6), $urandom, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    issue(0, 3'b010, 32'h80000100, 32'h0, 5'd7, 0, 20, 32'h12345678, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midwait_req_valid", {31'b0, mem_req_valid}, 0);
    check("midwait_in_ready", {31'b0, in_ready}, 0);
    check("midwait_outs", {29'b0, done, err, reg_wen}, 0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check("midwait_rel_in_ready", {31'b0, in_ready}, 1);
    repeat (30) @(negedge clk);
    issue(1, 3'b010, 32'h80000200, 32'h55AA55AA, 5'd0, 10, 0, 32'h0, 0);
    #2 check("midreq_valid_before", {31'b0, mem_req_valid}, 1);
    rst = 1'b0;
    #1 check("midreq_valid_drop", {31'b0, mem_req_valid}, 0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check("midreq_rel_in_ready", {31'b0, in_ready}, 1);
    repeat (30) @(negedge clk);
    check("leftover_exp", exp_q.size(), 0);
    check("leftover_req", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
